// File: rtl/alu_stage_ctrl_pkg.sv
// Shared definitions for the multi-cycle execute control FSM and its decoder.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package alu_stage_ctrl_pkg;

   // Phase register encoding; S_TRAP is only reachable when the trap feature is built.
   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_DEC  = 3'd1,
      S_EXEC = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_TRAP = 3'd5
   } state_t;

   // Instruction class, used by the FSM to pick the phase sequence.
   typedef enum logic [2:0] {
      IC_ALU   = 3'd0,
      IC_LOAD  = 3'd1,
      IC_STORE = 3'd2,
      IC_BEQ   = 3'd3,
      IC_BNE   = 3'd4,
      IC_JUMP  = 3'd5
   } iclass_t;

   // Opcodes (Instr[31:26]).
   localparam logic [5:0] OP_RTYPE = 6'b100000;
   localparam logic [5:0] OP_ADDI  = 6'b110000;
   localparam logic [5:0] OP_ANDI  = 6'b110010;
   localparam logic [5:0] OP_ORI   = 6'b110011;
   localparam logic [5:0] OP_LI    = 6'b111000;
   localparam logic [5:0] OP_LUI   = 6'b111001;
   localparam logic [5:0] OP_LW    = 6'b001111;
   localparam logic [5:0] OP_SW    = 6'b011111;
   localparam logic [5:0] OP_BEQ   = 6'b010000;
   localparam logic [5:0] OP_BNE   = 6'b010001;
   localparam logic [5:0] OP_B     = 6'b111111;

   // ALU function codes.
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;

   // Immediate extension modes.
   localparam logic [1:0] IMM_SIGN     = 2'b00;
   localparam logic [1:0] IMM_ZERO     = 2'b01;
   localparam logic [1:0] IMM_LUI      = 2'b10;
   localparam logic [1:0] IMM_SIGN_SL2 = 2'b11;

   // R-type func values the ALU actually implements.
   function automatic logic func_legal(input logic [3:0] f);
      case (f)
         4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
         4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: return 1'b1;
         default:                                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_stage_ctrl_decode.sv
// Combinational opcode/func decoder feeding the execute control FSM.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow the inputs.
// Ports: opcode/func in; alu_func, alu_bin_sel, imm_ext, iclass, legal out.
module alu_stage_ctrl_decode
   import alu_stage_ctrl_pkg::*;
#(
   parameter int ILLEGAL_FUNC_CHK = 1
) (
   input  logic [5:0] opcode,
   input  logic [3:0] func,
   output logic [3:0] alu_func,
   output logic       alu_bin_sel,
   output logic [1:0] imm_ext,
   output iclass_t    iclass,
   output logic       legal
);

   always_comb begin
      alu_func    = ALU_ADD;
      alu_bin_sel = 1'b0;
      imm_ext     = IMM_SIGN;
      iclass      = IC_ALU;
      legal       = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            alu_func = func;
            if (ILLEGAL_FUNC_CHK != 0 && !func_legal(func)) legal = 1'b0;
         end
         OP_ADDI, OP_LI: alu_bin_sel = 1'b1;
         OP_LW: begin
            alu_bin_sel = 1'b1;
            iclass      = IC_LOAD;
         end
         OP_SW: begin
            alu_bin_sel = 1'b1;
            iclass      = IC_STORE;
         end
         OP_ANDI: begin
            alu_func    = ALU_AND;
            alu_bin_sel = 1'b1;
            imm_ext     = IMM_ZERO;
         end
         OP_ORI: begin
            alu_func    = ALU_OR;
            alu_bin_sel = 1'b1;
            imm_ext     = IMM_ZERO;
         end
         OP_LUI: begin
            alu_bin_sel = 1'b1;
            imm_ext     = IMM_LUI;
         end
         // Branch compare is rs - rd; the offset is pre-shifted for the PC adder.
         OP_BEQ: begin
            alu_func = ALU_SUB;
            imm_ext  = IMM_SIGN_SL2;
            iclass   = IC_BEQ;
         end
         OP_BNE: begin
            alu_func = ALU_SUB;
            imm_ext  = IMM_SIGN_SL2;
            iclass   = IC_BNE;
         end
         OP_B: begin
            imm_ext = IMM_SIGN_SL2;
            iclass  = IC_JUMP;
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_stage_ctrl.sv
// Multi-cycle IF/DEC/EXEC/MEM/WB control FSM driving datapath selects and enables.
// Latency: ALU/imm 4, branch/jump 3, sw 4+waits, lw 5+waits cycles.
// Backpressure: MEM phase holds its strobe until Mem_ready=1.
// Ports: Clk, Reset_n, Instr, Zero, Mem_ready in; PC/IR/RF/ALU/Imm/Mem controls, Illegal_op out.
// Build option: ALU_STAGE_CTRL_TRAP_EN adds a TRAP state and a live Illegal_op flag.
module alu_stage_ctrl
   import alu_stage_ctrl_pkg::*;
#(
   parameter int ILLEGAL_FUNC_CHK = 1
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [31:0] Instr,
   input  logic        Zero,
   input  logic        Mem_ready,
   output logic        PC_LdEn,
   output logic        PC_sel,
   output logic        IR_LdEn,
   output logic        RF_WrEn,
   output logic        RF_WrData_sel,
   output logic        RF_B_sel,
   output logic        ALU_Bin_sel,
   output logic [3:0]  ALU_func,
   output logic [1:0]  Imm_ext,
   output logic        Mem_RdEn,
   output logic        Mem_WrEn,
   output logic        Illegal_op
);

   state_t     state;
   logic [3:0] dec_alu_func;
   logic       dec_bin_sel;
   logic [1:0] dec_imm_ext;
   iclass_t    dec_iclass;
   logic       dec_legal;
   logic       is_load;
   logic       is_store;
   logic       uses_rd;

   // Register-field bits are consumed by the datapath, not here.
   logic unused_instr;
   assign unused_instr = ^Instr[25:4];

   alu_stage_ctrl_decode #(
      .ILLEGAL_FUNC_CHK (ILLEGAL_FUNC_CHK)
   ) u_decode (
      .opcode      (Instr[31:26]),
      .func        (Instr[3:0]),
      .alu_func    (dec_alu_func),
      .alu_bin_sel (dec_bin_sel),
      .imm_ext     (dec_imm_ext),
      .iclass      (dec_iclass),
      .legal       (dec_legal)
   );

   assign is_load  = (dec_iclass == IC_LOAD);
   assign is_store = (dec_iclass == IC_STORE);
   // Branches compare against rd, and stores write rd's value to memory.
   assign uses_rd  = (dec_iclass == IC_BEQ) || (dec_iclass == IC_BNE) || is_store;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= S_IF;
      end else begin
         case (state)
            S_IF:  state <= S_DEC;
            S_DEC: begin
               if (dec_legal) state <= S_EXEC;
`ifdef ALU_STAGE_CTRL_TRAP_EN
               else           state <= S_TRAP;
`else
               else           state <= S_IF;
`endif
            end
            S_EXEC: begin
               case (dec_iclass)
                  IC_LOAD, IC_STORE:         state <= S_MEM;
                  IC_BEQ, IC_BNE, IC_JUMP:   state <= S_IF;
                  default:                   state <= S_WB;
               endcase
            end
            S_MEM: begin
               if (Mem_ready) state <= is_load ? S_WB : S_IF;
            end
            S_WB:  state <= S_IF;
`ifdef ALU_STAGE_CTRL_TRAP_EN
            S_TRAP: state <= S_TRAP;
`endif
            default: state <= S_IF;
         endcase
      end
   end

   // Outputs are gated by Reset_n so every enable drops the instant reset asserts,
   // even though the state register itself already sits in S_IF.
   always_comb begin
      PC_LdEn       = 1'b0;
      PC_sel        = 1'b0;
      IR_LdEn       = 1'b0;
      RF_WrEn       = 1'b0;
      RF_WrData_sel = 1'b0;
      RF_B_sel      = 1'b0;
      ALU_Bin_sel   = 1'b0;
      ALU_func      = ALU_ADD;
      Imm_ext       = IMM_SIGN;
      Mem_RdEn      = 1'b0;
      Mem_WrEn      = 1'b0;
      if (Reset_n) begin
         case (state)
            S_IF: IR_LdEn = 1'b1;
            S_DEC: begin
               Imm_ext  = dec_imm_ext;
               RF_B_sel = uses_rd;
`ifndef ALU_STAGE_CTRL_TRAP_EN
               // Illegal instruction retires as a NOP: just step the PC.
               PC_LdEn  = !dec_legal;
`endif
            end
            S_EXEC: begin
               ALU_func    = dec_alu_func;
               ALU_Bin_sel = dec_bin_sel;
               Imm_ext     = dec_imm_ext;
               RF_B_sel    = uses_rd;
               case (dec_iclass)
                  IC_BEQ: begin
                     PC_LdEn = 1'b1;
                     PC_sel  = Zero;
                  end
                  IC_BNE: begin
                     PC_LdEn = 1'b1;
                     PC_sel  = !Zero;
                  end
                  IC_JUMP: begin
                     PC_LdEn = 1'b1;
                     PC_sel  = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               // Keep the address computation stable across wait cycles.
               ALU_func    = dec_alu_func;
               ALU_Bin_sel = dec_bin_sel;
               Imm_ext     = dec_imm_ext;
               RF_B_sel    = is_store;
               Mem_RdEn    = is_load;
               Mem_WrEn    = is_store;
               PC_LdEn     = is_store && Mem_ready;
            end
            S_WB: begin
               RF_WrEn       = 1'b1;
               RF_WrData_sel = is_load;
               PC_LdEn       = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_STAGE_CTRL_TRAP_EN
   assign Illegal_op = Reset_n && (state == S_TRAP);
`else
   assign Illegal_op = 1'b0;
`endif

endmodule
